// File: rtl/vio_pkg.sv
// vio_pkg: state encoding and counter sizing shared by the JTAG VIO driver.
package vio_pkg;

   localparam int DATA_W_MAX = 64;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] CAPTURE = 2'd1;
   localparam logic [1:0] SHIFT   = 2'd2;
   localparam logic [1:0] UPDATE  = 2'd3;

   // bit counter must hold 0..n+1 so an over-long shift stays distinguishable
   function automatic int cnt_w(input int n);
      return $clog2(n + 2);
   endfunction

endpackage

// File: rtl/jtag_edge_sync.sv
// jtag_edge_sync: brings one JTAG-domain bit into sys_clk and flags its edges.
module jtag_edge_sync
   import vio_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic s,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain <= '0;
         prev  <= 1'b0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
         prev  <= chain[STAGES-1];
      end
   end

   assign s    = chain[STAGES-1];
   assign rise = s & ~prev;
   assign fall = ~s & prev;

endmodule

// File: rtl/jtag_vio_driver.sv
// jtag_vio_driver: ER2 user-chain word driven onto probe_out, probe_in read back on TDO.
// Define VIO_AUTOCLEAR_EN for momentary outputs that revert after PULSE_CYCLES.
module jtag_vio_driver
   import vio_pkg::*;
#(
   parameter int                DATA_W       = 28,
   parameter logic [DATA_W-1:0] RST_VAL      = '0,
   parameter int                SYNC_STAGES  = 2,
   parameter int                PULSE_CYCLES = 16
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              tck_i,
   input  logic              tdi_i,
   input  logic              enable_i,
   input  logic              shift_capture_i,
   input  logic              update_i,
   input  logic              reset_i,
   output logic              tdo_o,
   input  logic [DATA_W-1:0] probe_in,
   output logic [DATA_W-1:0] probe_out,
   output logic              out_valid,
   output logic              len_err
);

   localparam int             CW   = cnt_w(DATA_W);
   localparam logic [CW-1:0] FULL = CW'(DATA_W);
   localparam logic [CW-1:0] SAT  = CW'(DATA_W + 1);

   logic tck_rise, tck_fall, sc_s, upd_rise, en_s, rst_s, tdi_s;
   logic tck_unused, sc_rise_unused, sc_fall_unused, upd_s_unused;
   logic upd_fall_unused, en_rise_unused, en_fall_unused;
   logic rst_rise_unused, rst_fall_unused;
   logic range_unused;

   logic [1:0]             state;
   logic [DATA_W-1:0]      sr;
   logic [CW-1:0]          cnt;
   logic [SYNC_STAGES-1:0] tdi_q;

   assign range_unused = (DATA_W <= DATA_W_MAX);

   jtag_edge_sync #(.STAGES(SYNC_STAGES)) u_tck (
      .clk(sys_clk), .rst(sys_rst), .d(tck_i),
      .s(tck_unused), .rise(tck_rise), .fall(tck_fall));

   jtag_edge_sync #(.STAGES(SYNC_STAGES)) u_sc (
      .clk(sys_clk), .rst(sys_rst), .d(shift_capture_i),
      .s(sc_s), .rise(sc_rise_unused), .fall(sc_fall_unused));

   jtag_edge_sync #(.STAGES(SYNC_STAGES)) u_upd (
      .clk(sys_clk), .rst(sys_rst), .d(update_i),
      .s(upd_s_unused), .rise(upd_rise), .fall(upd_fall_unused));

   jtag_edge_sync #(.STAGES(SYNC_STAGES)) u_en (
      .clk(sys_clk), .rst(sys_rst), .d(enable_i),
      .s(en_s), .rise(en_rise_unused), .fall(en_fall_unused));

   jtag_edge_sync #(.STAGES(SYNC_STAGES)) u_rst (
      .clk(sys_clk), .rst(sys_rst), .d(reset_i),
      .s(rst_s), .rise(rst_rise_unused), .fall(rst_fall_unused));

   // same depth as the tck path so tdi_s lines up with tck_rise
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) tdi_q <= '0;
      else         tdi_q <= {tdi_q[SYNC_STAGES-2:0], tdi_i};
   end
   assign tdi_s = tdi_q[SYNC_STAGES-1];

`ifdef VIO_AUTOCLEAR_EN
   localparam int HW = $clog2(PULSE_CYCLES + 1);
   logic [HW-1:0] hold;
   logic          hold_on;
`else
   logic [31:0] pulse_unused;
   assign pulse_unused = 32'(PULSE_CYCLES);
`endif

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state     <= IDLE;
         sr        <= '0;
         cnt       <= '0;
         tdo_o     <= 1'b0;
         probe_out <= RST_VAL;
         out_valid <= 1'b0;
         len_err   <= 1'b0;
`ifdef VIO_AUTOCLEAR_EN
         hold      <= '0;
         hold_on   <= 1'b0;
`endif
      end else begin
         out_valid <= 1'b0;
`ifdef VIO_AUTOCLEAR_EN
         if (hold_on) begin
            if (hold == '0) begin
               probe_out <= RST_VAL;
               hold_on   <= 1'b0;
            end else begin
               hold <= hold - 1'b1;
            end
         end
`endif
         if (rst_s) begin
            state <= IDLE;
            cnt   <= '0;
         end else if (en_s && upd_rise) begin
            // judged on the count before any coincident tck edge
            state <= UPDATE;
            if (cnt == FULL) begin
               probe_out <= sr;
               out_valid <= 1'b1;
               len_err   <= 1'b0;
`ifdef VIO_AUTOCLEAR_EN
               hold      <= HW'(PULSE_CYCLES - 1);
               hold_on   <= 1'b1;
`endif
            end else begin
               len_err <= 1'b1;
            end
         end else if (state == UPDATE) begin
            state <= IDLE;
         end else if (en_s) begin
            if (tck_fall && state == SHIFT)
               tdo_o <= sr[0];
            if (tck_rise && sc_s) begin
               case (state)
                  IDLE: begin
                     state <= CAPTURE;
                     sr    <= probe_in;
                     cnt   <= '0;
                  end
                  CAPTURE: state <= SHIFT;
                  SHIFT: begin
                     sr <= (sr >> 1) | (DATA_W'(tdi_s) << (DATA_W - 1));
                     if (cnt != SAT) cnt <= cnt + 1'b1;
                  end
                  default: state <= IDLE;
               endcase
            end else if (!sc_s && state != IDLE) begin
               state <= IDLE;
            end
         end
      end
   end

endmodule

// File: tb/tb_jtag_vio_driver.sv
// tb_jtag_vio_driver: directed JTAG host transactions against a word-level model.
module tb_jtag_vio_driver;

   localparam int             W     = 28;
   localparam int             SYNC  = 2;
   localparam int             PULSE = 16;
   localparam logic [W-1:0]   RST   = '0;
`ifdef VIO_AUTOCLEAR_EN
   localparam bit AUTOCLR = 1'b1;
`else
   localparam bit AUTOCLR = 1'b0;
`endif

   logic         sys_clk = 1'b0;
   logic         sys_rst = 1'b1;
   logic         tck_i = 1'b0, tdi_i = 1'b0, enable_i = 1'b0;
   logic         shift_capture_i = 1'b0, update_i = 1'b0, reset_i = 1'b0;
   logic         tdo_o, out_valid, len_err;
   logic [W-1:0] probe_in = '0;
   logic [W-1:0] probe_out;

   jtag_vio_driver #(
      .DATA_W(W), .RST_VAL(RST), .SYNC_STAGES(SYNC), .PULSE_CYCLES(PULSE)
   ) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .tck_i(tck_i), .tdi_i(tdi_i),
      .enable_i(enable_i), .shift_capture_i(shift_capture_i),
      .update_i(update_i), .reset_i(reset_i), .tdo_o(tdo_o),
      .probe_in(probe_in), .probe_out(probe_out),
      .out_valid(out_valid), .len_err(len_err));

   always #5 sys_clk = ~sys_clk;

   // model: update requests land SYNC+1 clocks after the pad edge
   typedef struct {
      int           due;
      logic         ok;
      logic [W-1:0] val;
   } ev_t;

   ev_t          evq[$];
   int           cyc = 0;
   int           ev_idx = 0;
   logic [W-1:0] m_probe = RST;
   logic         m_valid = 1'b0;
   logic         m_len = 1'b0;
`ifdef VIO_AUTOCLEAR_EN
   int           hold_left = 0;
`endif

   always @(posedge sys_clk) begin
      cyc     <= cyc + 1;
      m_valid <= 1'b0;
      if (sys_rst) begin
         m_probe <= RST;
         m_len   <= 1'b0;
         ev_idx  <= evq.size();
`ifdef VIO_AUTOCLEAR_EN
         hold_left <= 0;
`endif
      end else begin
`ifdef VIO_AUTOCLEAR_EN
         if (hold_left == 1) m_probe <= RST;
         if (hold_left > 0) hold_left <= hold_left - 1;
`endif
         if (ev_idx < evq.size() && evq[ev_idx].due == cyc + 1) begin
            ev_idx <= ev_idx + 1;
            if (evq[ev_idx].ok) begin
               m_probe <= evq[ev_idx].val;
               m_valid <= 1'b1;
               m_len   <= 1'b0;
`ifdef VIO_AUTOCLEAR_EN
               hold_left <= PULSE;
`endif
            end else begin
               m_len <= 1'b1;
            end
         end
      end
   end

   // host-side view of the chain
   logic [W-1:0] h_cap = '0, h_d = '0, tdo_word = '0;
   int           h_nb = 0;
   int           n_checks = 0, n_pass = 0, vcount = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   function automatic logic [W-1:0] exp_sr();
      logic [2*W-1:0] cat;
      cat = {h_d, h_cap};
      return W'(cat >> h_nb);
   endfunction

   task automatic post_update();
      evq.push_back('{cyc + SYNC + 1, (h_nb == W), exp_sr()});
   endtask

   task automatic start_shift(input logic [W-1:0] pin);
      probe_in        = pin;
      shift_capture_i = 1'b1;
      tck_i = 1'b0; tick(4);
      tck_i = 1'b1; tick(4);
      tck_i = 1'b0; tick(4);
      tck_i = 1'b1; tick(4);
      h_cap = pin;
      h_nb  = 0;
   endtask

   task automatic shift_bits(input logic [W-1:0] d, input int n);
      for (int i = 0; i < n; i++) begin
         tdi_i = d[i];
         tck_i = 1'b0;
         tick(4);
         tdo_word[i] = tdo_o;
         check("tdo_bit", 64'(tdo_o), 64'(h_cap[i]));
         tck_i = 1'b1;
         tick(4);
      end
      h_d  = d;
      h_nb = n;
   endtask

   task automatic do_update();
      tck_i = 1'b0; tick(4);
      shift_capture_i = 1'b0; tick(4);
      update_i = 1'b1;
      post_update();
      tick(4);
      update_i = 1'b0;
      tick(6);
   endtask

   task automatic update_on_rise();
      tdi_i = 1'b1;
      tck_i = 1'b0; tick(4);
      tck_i = 1'b1;
      update_i = 1'b1;
      post_update();
      tick(4);
      tck_i = 1'b0;
      update_i = 1'b0;
      tick(4);
      shift_capture_i = 1'b0;
      tick(6);
   endtask

   initial begin
      fork
         forever begin
            @(negedge sys_clk);
            if (!sys_rst) begin
               check("cycle_outputs", 64'({probe_out, out_valid, len_err}),
                     64'({m_probe, m_valid, m_len}));
               if (out_valid) vcount++;
            end
         end
      join_none

      tick(3);
      check("rst_probe", 64'(probe_out), 64'(0));
      check("rst_valid", 64'(out_valid), 64'(0));
      check("rst_len", 64'(len_err), 64'(0));
      check("rst_tdo", 64'(tdo_o), 64'(0));
      sys_rst = 1'b0;
      tick(2);
      enable_i = 1'b1;
      tick(4);

      start_shift(28'h0ABCDEF);
      shift_bits(28'h5A5A5A5, 28);
      do_update();
      check("full_tdo_stream", 64'(tdo_word), 64'(28'h0ABCDEF));
      check("full_probe", 64'(probe_out), 64'(28'h5A5A5A5));
      check("full_pulses", 64'(vcount), 64'(1));
      check("full_len", 64'(len_err), 64'(0));

      start_shift(28'h1234567);
      shift_bits(28'h0F0F0F0, 27);
      do_update();
      check("short_probe", 64'(probe_out),
            64'(AUTOCLR ? RST : 28'h5A5A5A5));
      check("short_len", 64'(len_err), 64'(1));
      check("short_pulses", 64'(vcount), 64'(1));

      start_shift(28'h7654321);
      shift_bits(28'h0C3C3C3, 28);
      do_update();
      check("fix_probe", 64'(probe_out), 64'(28'h0C3C3C3));
      check("fix_len", 64'(len_err), 64'(0));
      check("fix_pulses", 64'(vcount), 64'(2));

      start_shift(28'h0000FFF);
      shift_bits(28'h9876543, 28);
      update_on_rise();
      check("simul_probe", 64'(probe_out), 64'(28'h9876543));
      check("simul_len", 64'(len_err), 64'(0));
      check("simul_pulses", 64'(vcount), 64'(3));

      start_shift(28'h0333333);
      shift_bits(28'h1111111, 10);
      tck_i = 1'b0;
      shift_capture_i = 1'b0;
      tick(4);
      reset_i = 1'b1; tick(4);
      reset_i = 1'b0; tick(4);
      h_nb = 0;
      do_update();
      check("treset_reject_len", 64'(len_err), 64'(1));
      check("treset_reject_probe", 64'(probe_out),
            64'(AUTOCLR ? RST : 28'h9876543));
      start_shift(28'h0555555);
      shift_bits(28'h2468ACE, 28);
      do_update();
      check("treset_fresh_probe", 64'(probe_out), 64'(28'h2468ACE));
      check("treset_fresh_len", 64'(len_err), 64'(0));

      start_shift(28'h0777777);
      shift_bits(28'h0FEDCBA, 10);
      sys_rst = 1'b1;
      #1;
      check("sysrst_probe", 64'(probe_out), 64'(RST));
      check("sysrst_valid", 64'(out_valid), 64'(0));
      check("sysrst_len", 64'(len_err), 64'(0));
      check("sysrst_tdo", 64'(tdo_o), 64'(0));
      tck_i = 1'b0;
      tdi_i = 1'b0;
      shift_capture_i = 1'b0;
      h_cap = '0;
      h_d = '0;
      h_nb = 0;
      tick(3);
      sys_rst = 1'b0;
      tick(6);

      start_shift(28'h0F00F0F);
      shift_bits(28'h3C3C3C3, 28);
      do_update();
      check("post_rst_probe", 64'(probe_out), 64'(28'h3C3C3C3));
      check("post_rst_tdo_stream", 64'(tdo_word), 64'(28'h0F00F0F));

`ifdef VIO_AUTOCLEAR_EN
      begin : g_autoclear
         int hi;
         start_shift(28'h0);
         shift_bits(28'h1, W);
         tck_i = 1'b0; tick(4);
         shift_capture_i = 1'b0; tick(4);
         hi = 0;
         update_i = 1'b1;
         post_update();
         for (int k = 0; k < 40; k++) begin
            tick(1);
            if (k == 3) update_i = 1'b0;
            if (probe_out == W'(1)) hi++;
         end
         check("autoclear_hold", 64'(hi), 64'(16));
         hi = 0;
         update_i = 1'b1;
         post_update();
         for (int k = 0; k < 50; k++) begin
            tick(1);
            if (k == 3) update_i = 1'b0;
            if (k == 7) begin
               update_i = 1'b1;
               post_update();
            end
            if (k == 11) update_i = 1'b0;
            if (probe_out == W'(1)) hi++;
         end
         check("autoclear_extend", 64'(hi), 64'(24));
      end
`endif

      tick(4);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
